data_chk: RTL and testbench

- Receive-side checker for the 2-bit PAM4 symbol link test stream.
- Hunts for the fixed 10-symbol frame header in the incoming symbol stream, then locks a local PRBS generator to the payload.
- Compares every payload symbol against the local generator and accumulates symbol and bit error counts.
- Sits after the symbol slicer/deserializer and feeds BER reporting logic.

---
 rtl/data_chk_pkg.sv | 27 ++
 rtl/data_chk_prbs_any.sv | 49 ++++
 rtl/data_chk.sv | 217 +++++++++++++++++++++
 tb/tb_data_chk.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/data_chk_pkg.sv
// Shared definitions for the PAM4 link-test checker: FSM encodings,
// frame header symbols (also used by the transmitter) and symbol helpers.
package data_chk_pkg;

    localparam int SYM_W    = 2;
    localparam int HEAD_LEN = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [SYM_W-1:0] HEAD_SYM_LO = 2'd0;
    localparam logic [SYM_W-1:0] HEAD_SYM_HI = 2'd3;

    // Oldest symbol in the most significant position.
    localparam logic [HEAD_LEN*SYM_W-1:0] HEAD_PATTERN = {
        HEAD_SYM_LO, HEAD_SYM_LO, HEAD_SYM_HI, HEAD_SYM_HI, HEAD_SYM_LO,
        HEAD_SYM_LO, HEAD_SYM_HI, HEAD_SYM_HI, HEAD_SYM_LO, HEAD_SYM_LO
    };

    function automatic logic [1:0] sym_bit_errs(input logic [SYM_W-1:0] diff);
        return {1'b0, diff[0]} + {1'b0, diff[1]};
    endfunction

endpackage

// File: rtl/data_chk_prbs_any.sv
// PRBS_ANY: generic LFSR pattern generator/checker producing NBITS bits per
// enabled clock; CHK_MODE=0 generates, CHK_MODE=1 self-synchronises to DATA_IN.
module PRBS_ANY #(
    parameter bit CHK_MODE    = 1'b0,
    parameter int INV_PATTERN = 0,
    parameter int POLY_LENGHT = 31,
    parameter int POLY_TAP    = 3,
    parameter int NBITS       = 16
) (
    input  logic             RST,
    input  logic             CLK,
    input  logic [NBITS-1:0] DATA_IN,
    input  logic             EN,
    output logic [NBITS-1:0] DATA_OUT
);

    logic [POLY_LENGHT:1] prbs_q;
    logic [POLY_LENGHT:1] prbs_d;
    logic [POLY_LENGHT:1] prbs_walk;
    logic [NBITS-1:0]     data_in_i;
    logic [NBITS-1:0]     prbs_xor_b;
    logic                 fb;

    assign data_in_i = (INV_PATTERN == 0) ? DATA_IN : ~DATA_IN;

    // Bit 0 is produced first; each bit advances the register by one step.
    always_comb begin
        prbs_walk  = prbs_q;
        prbs_xor_b = '0;
        fb         = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            fb            = prbs_walk[POLY_TAP] ^ prbs_walk[POLY_LENGHT];
            prbs_xor_b[i] = fb ^ data_in_i[i];
            prbs_walk     = {prbs_walk[POLY_LENGHT-1:1], (CHK_MODE ? data_in_i[i] : fb)};
        end
        prbs_d = prbs_walk;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prbs_q   <= '1;
            DATA_OUT <= '1;
        end else if (EN) begin
            prbs_q   <= prbs_d;
            DATA_OUT <= prbs_xor_b;
        end
    end

endmodule

// File: rtl/data_chk.sv
// PAM4 link-test receive checker: header hunt, PRBS lock and error statistics.
// Optional loss-of-lock monitor is built when DATA_CHK_LOL_EN is defined.
module data_chk
    import data_chk_pkg::*;
#(
    parameter int INV_PATTERN = 1,
    parameter int POLY_LENGHT = 9,
    parameter int POLY_TAP    = 5,
    parameter int HEAD_LENGTH = 10,
    parameter int CNT_W       = 32,
    parameter int LOL_WINDOW  = 256,
    parameter int LOL_THRESH  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYM_W-1:0] data_in,
    input  logic             chk_enable,
    input  logic             chk_clear,
    output logic             locked,
    output logic [CNT_W-1:0] sym_cnt,
    output logic [CNT_W-1:0] sym_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic             err_flag,
    output logic [15:0]      lol_cnt
);

    localparam int WIN_W = HEAD_LENGTH * SYM_W;
    localparam int SR_W  = WIN_W - SYM_W;

    if (HEAD_LENGTH != HEAD_LEN) begin : g_bad_head
        $error("data_chk: only a 10-symbol header is supported");
    end
    if (((LOL_WINDOW & (LOL_WINDOW - 1)) != 0) || (LOL_THRESH < 1) || (LOL_THRESH > LOL_WINDOW)) begin : g_bad_lol
        $error("data_chk: LOL_WINDOW must be a power of 2 and LOL_THRESH within it");
    end

    state_t           state_q;
    logic             locked_q;
    logic             err_flag_q;
    logic [SR_W-1:0]  sr_q;
    logic [WIN_W-1:0] window;
    logic             hdr_match;
    logic             match_cycle;
    logic             gen_rst;
    logic             gen_en;
    logic [SYM_W-1:0] expected;
    logic [SYM_W-1:0] diff;
    logic             compare;
    logic             sym_mismatch;
    logic             lol_event;

    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] sym_err_q, sym_err_d;
    logic [CNT_W-1:0] bit_err_q, bit_err_d;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign window      = {sr_q, data_in};
    assign hdr_match   = (window == HEAD_PATTERN);
    assign match_cycle = chk_enable && (state_q == ST_HUNT) && hdr_match;

    // Generator sits in reset until the header's last symbol, then steps with
    // the transmitter so its output lines up with the first payload symbol.
    assign gen_rst = rst || ((state_q != ST_CHECK) && !match_cycle);
    assign gen_en  = match_cycle || (state_q == ST_CHECK);

    PRBS_ANY #(
        .CHK_MODE    (1'b0),
        .INV_PATTERN (INV_PATTERN),
        .POLY_LENGHT (POLY_LENGHT),
        .POLY_TAP    (POLY_TAP),
        .NBITS       (SYM_W)
    ) u_prbs (
        .RST      (gen_rst),
        .CLK      (clk),
        .DATA_IN  ({SYM_W{1'b0}}),
        .EN       (gen_en),
        .DATA_OUT (expected)
    );

    assign compare      = chk_enable && (state_q == ST_CHECK);
    assign diff         = data_in ^ expected;
    assign sym_mismatch = |diff;

    always_comb begin
        sym_cnt_d = sym_cnt_q;
        sym_err_d = sym_err_q;
        bit_err_d = bit_err_q;
        if (compare) begin
            sym_cnt_d = sat_add(sym_cnt_q, 2'd1);
            if (sym_mismatch) begin
                sym_err_d = sat_add(sym_err_q, 2'd1);
                bit_err_d = sat_add(bit_err_q, sym_bit_errs(diff));
            end
        end
        if (chk_clear) begin
            sym_cnt_d = '0;
            sym_err_d = '0;
            bit_err_d = '0;
        end
    end

`ifdef DATA_CHK_LOL_EN
    localparam int WCNT_W = $clog2(LOL_WINDOW);
    localparam int ECNT_W = $clog2(LOL_THRESH + 1);

    logic [WCNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [ECNT_W-1:0] win_err_q, win_err_d;
    logic [15:0]       lol_cnt_q, lol_cnt_d;

    // Window restarts whenever we are not checking, on wrap and on a trip.
    always_comb begin
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        lol_event = 1'b0;
        if (state_q != ST_CHECK) begin
            win_cnt_d = '0;
            win_err_d = '0;
        end else if (compare) begin
            if (sym_mismatch && (win_err_q == ECNT_W'(LOL_THRESH - 1))) begin
                lol_event = 1'b1;
                win_cnt_d = '0;
                win_err_d = '0;
            end else if (win_cnt_q == WCNT_W'(LOL_WINDOW - 1)) begin
                win_cnt_d = '0;
                win_err_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + WCNT_W'(1);
                win_err_d = win_err_q + ECNT_W'(sym_mismatch);
            end
        end
    end

    always_comb begin
        lol_cnt_d = lol_cnt_q;
        if (lol_event && (lol_cnt_q != '1)) begin
            lol_cnt_d = lol_cnt_q + 16'd1;
        end
        if (chk_clear) begin
            lol_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
            lol_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            lol_cnt_q <= lol_cnt_d;
        end
    end

    assign lol_cnt = lol_cnt_q;
`else
    assign lol_event = 1'b0;
    assign lol_cnt   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            locked_q   <= 1'b0;
            err_flag_q <= 1'b0;
            sr_q       <= '0;
            sym_cnt_q  <= '0;
            sym_err_q  <= '0;
            bit_err_q  <= '0;
        end else begin
            sr_q       <= {sr_q[SR_W-SYM_W-1:0], data_in};
            err_flag_q <= compare && sym_mismatch;
            sym_cnt_q  <= sym_cnt_d;
            sym_err_q  <= sym_err_d;
            bit_err_q  <= bit_err_d;
            if (!chk_enable) begin
                state_q  <= ST_IDLE;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q  <= ST_HUNT;
                        locked_q <= 1'b0;
                    end
                    ST_HUNT: begin
                        if (hdr_match) begin
                            state_q  <= ST_CHECK;
                            locked_q <= 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        if (lol_event) begin
                            state_q  <= ST_HUNT;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked      = locked_q;
    assign err_flag    = err_flag_q;
    assign sym_cnt     = sym_cnt_q;
    assign sym_err_cnt = sym_err_q;
    assign bit_err_cnt = bit_err_q;

endmodule

// File: tb/tb_data_chk.sv
// Directed bench for data_chk: header hunt, clean PRBS payload, injected
// errors, loss of lock (DATA_CHK_LOL_EN aware), clear/enable/reset control.
module tb_data_chk;

    logic        clk;
    logic        rst;
    logic [1:0]  data_in;
    logic        chk_enable;
    logic        chk_clear;
    logic        locked;
    logic [31:0] sym_cnt;
    logic [31:0] sym_err_cnt;
    logic [31:0] bit_err_cnt;
    logic        err_flag;
    logic [15:0] lol_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulses = 0;

    logic [8:0] lfsr;
    logic [1:0] sym;

    logic [1:0] hdr  [10] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0};
    logic [1:0] near [10] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd3};

    data_chk dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .chk_enable  (chk_enable),
        .chk_clear   (chk_clear),
        .locked      (locked),
        .sym_cnt     (sym_cnt),
        .sym_err_cnt (sym_err_cnt),
        .bit_err_cnt (bit_err_cnt),
        .err_flag    (err_flag),
        .lol_cnt     (lol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Transmitter model: PRBS9 (x^9 + x^5 + 1), inverted output, LSB first.
    task automatic prbs_next(output logic [1:0] s);
        logic f;
        for (int b = 0; b < 2; b++) begin
            f    = lfsr[4] ^ lfsr[8];
            lfsr = {lfsr[7:0], f};
            s[b] = ~f;
        end
    endtask

    task automatic send(input logic [1:0] s);
        data_in = s;
        @(posedge clk);
        #1;
        if (err_flag) n_pulses++;
    endtask

    initial begin
        rst        = 1'b1;
        chk_enable = 1'b0;
        chk_clear  = 1'b0;
        data_in    = 2'd0;
        lfsr       = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_sym_cnt", sym_cnt, 0);
        check("rst_sym_err", sym_err_cnt, 0);
        check("rst_lol_cnt", lol_cnt, 0);

        rst        = 1'b0;
        chk_enable = 1'b1;
        send(2'd1);
        send(2'd2);
        for (int i = 0; i < 10; i++) send(near[i]);
        check("near_miss_locked", locked, 0);
        send(2'd1);
        check("near_miss_locked2", locked, 0);
        for (int i = 0; i < 9; i++) send(hdr[i]);
        check("locked_before_m", locked, 0);
        send(hdr[9]);
        check("locked_at_m1", locked, 1);

        // Clean run of 1000 payload symbols
        lfsr     = '1;
        n_pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            prbs_next(sym);
            send(sym);
            if (i == 0) check("first_cmp_sym_cnt", sym_cnt, 1);
        end
        check("clean_sym_cnt", sym_cnt, 1000);
        check("clean_sym_err", sym_err_cnt, 0);
        check("clean_bit_err", bit_err_cnt, 0);
        check("clean_err_pulses", n_pulses, 0);
        check("clean_locked", locked, 1);

        // Clear coinciding with a compared symbol: clear wins
        chk_clear = 1'b1;
        prbs_next(sym);
        send(sym);
        chk_clear = 1'b0;
        check("clear_sym_cnt", sym_cnt, 0);
        check("clear_locked", locked, 1);

        // Two injected errors: two bits at 100, one bit at 200
        n_pulses = 0;
        for (int k = 0; k < 300; k++) begin
            prbs_next(sym);
            if (k == 100) sym = sym ^ 2'b11;
            if (k == 200) sym = sym ^ 2'b01;
            send(sym);
            if (k == 100) check("err_flag_hit", err_flag, 1);
            if (k == 101) check("err_flag_next", err_flag, 0);
        end
        check("inj_sym_cnt", sym_cnt, 300);
        check("inj_sym_err", sym_err_cnt, 2);
        check("inj_bit_err", bit_err_cnt, 3);
        check("inj_err_pulses", n_pulses, 2);

        // 32 consecutive corrupted symbols inside one window
        for (int k = 0; k < 32; k++) begin
            prbs_next(sym);
            send(sym ^ 2'b11);
            if (k == 30) check("lol_31_locked", locked, 1);
        end
        check("lol_sym_err", sym_err_cnt, 34);
        check("lol_bit_err", bit_err_cnt, 67);
`ifdef DATA_CHK_LOL_EN
        check("lol_locked", locked, 0);
        check("lol_cnt", lol_cnt, 1);
`else
        check("lol_locked", locked, 1);
        check("lol_cnt", lol_cnt, 0);
`endif

        // Drop enable: IDLE, counters hold
        chk_enable = 1'b0;
        send(2'd0);
        check("dis_locked", locked, 0);
        check("dis_sym_cnt", sym_cnt, 332);
        check("dis_sym_err", sym_err_cnt, 34);

        chk_enable = 1'b1;
        for (int i = 0; i < 5; i++) send(2'd1);
        check("reen_no_lock", locked, 0);
        for (int i = 0; i < 10; i++) send(hdr[i]);
        check("relock", locked, 1);
        lfsr = '1;
        for (int i = 0; i < 5; i++) begin
            prbs_next(sym);
            send(sym);
        end
        check("relock_sym_cnt", sym_cnt, 337);
        check("relock_sym_err", sym_err_cnt, 34);

        // Reset mid-check
        rst = 1'b1;
        send(2'd3);
        rst = 1'b0;
        check("midrst_locked", locked, 0);
        check("midrst_sym_cnt", sym_cnt, 0);
        check("midrst_sym_err", sym_err_cnt, 0);
        check("midrst_bit_err", bit_err_cnt, 0);
        check("midrst_err_flag", err_flag, 0);
        check("midrst_lol_cnt", lol_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
